// File: rtl/c4_pkg.sv
// Shared connect-four definitions: board geometry, FSM states and player encoding.
// Used by the move controller and by the downstream logic unit.
package c4_pkg;

  localparam int COLS      = 7;
  localparam int ROWS      = 6;
  localparam int MAX_MOVES = 42;

  localparam logic P1 = 1'b0;
  localparam logic P2 = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    ISSUE = 2'd2
  } state_t;

endpackage

// File: rtl/c4_col_next.sv
// Next-state of one board column: thermometer occupancy grows by one cell and the
// owner bit at the new height takes the mover's value. full flags a column with no room.
module c4_col_next
  import c4_pkg::*;
#(
  parameter int ROWS = c4_pkg::ROWS
) (
  input  logic [ROWS-1:0] onoff,
  input  logic [ROWS-1:0] owner,
  input  logic            player,
  output logic [ROWS-1:0] new_onoff,
  output logic [ROWS-1:0] new_owner,
  output logic            full
);

  int h;

  always_comb begin
    h = 0;
    for (int i = 0; i < ROWS; i++) begin
      if (onoff[i]) h = h + 1;
    end
    full      = onoff[ROWS-1];
    new_onoff = {onoff[ROWS-2:0], 1'b1};
    new_owner = owner;
    // h is the height of the first empty cell; nothing to place when full
    for (int i = 0; i < ROWS; i++) begin
      if (!full && (i == h)) new_owner[i] = player;
    end
  end

endmodule

// File: rtl/c4_move_ctrl.sv
// Connect-four move controller: legality check against a shadow board, write strobe to
// the logic unit, turn and move tracking. Define C4_DROP_EDGE_EN for edge-triggered drop.
module c4_move_ctrl
  import c4_pkg::*;
#(
  parameter int   COLS         = c4_pkg::COLS,
  parameter int   ROWS         = c4_pkg::ROWS,
  parameter logic FIRST_PLAYER = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [2:0]      col_sel,
  input  logic            drop,
  input  logic            game_over,
  output logic [2:0]      address,
  output logic [ROWS-1:0] onoff_write,
  output logic [ROWS-1:0] player_write,
  output logic            go,
  output logic            cur_player,
  output logic [5:0]      move_count,
  output logic            illegal,
  output logic            board_full
);

  localparam logic [3:0] COLS_W  = 4'(COLS);
  localparam logic [5:0] CELLS_W = 6'(COLS * ROWS);
  localparam logic [5:0] MAX_W   = 6'(MAX_MOVES);

  state_t          state;
  logic [2:0]      col_r;
  logic [ROWS-1:0] onoff_b [8];
  logic [ROWS-1:0] owner_b [8];
  logic            req;
  logic [ROWS-1:0] new_onoff_c;
  logic [ROWS-1:0] new_owner_c;
  logic            full_c;
  logic            legal;

`ifdef C4_DROP_EDGE_EN
  // Previous value resets high so a button held through reset is not a request
  logic drop_prev;
  always_ff @(posedge clk) begin
    if (reset) drop_prev <= 1'b1;
    else       drop_prev <= drop;
  end
  assign req = drop & ~drop_prev;
`else
  assign req = drop;
`endif

  c4_col_next #(.ROWS(ROWS)) u_col_next (
    .onoff     (onoff_b[col_r]),
    .owner     (owner_b[col_r]),
    .player    (cur_player),
    .new_onoff (new_onoff_c),
    .new_owner (new_owner_c),
    .full      (full_c)
  );

  assign legal = ({1'b0, col_r} < COLS_W) && !full_c && !game_over && !board_full;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      address      <= '0;
      onoff_write  <= '0;
      player_write <= '0;
      go           <= 1'b0;
      illegal      <= 1'b0;
      cur_player   <= FIRST_PLAYER;
      move_count   <= '0;
      board_full   <= 1'b0;
      for (int c = 0; c < 8; c++) begin
        onoff_b[c] <= '0;
        owner_b[c] <= '0;
      end
    end else begin
      go         <= 1'b0;
      illegal    <= 1'b0;
      board_full <= (move_count == CELLS_W);
      case (state)
        IDLE: begin
          if (req) begin
            col_r <= col_sel;
            state <= CHECK;
          end
        end
        CHECK: begin
          if (legal) begin
            address          <= col_r;
            onoff_write      <= new_onoff_c;
            player_write     <= new_owner_c;
            go               <= 1'b1;
            onoff_b[col_r]   <= new_onoff_c;
            owner_b[col_r]   <= new_owner_c;
            state            <= ISSUE;
          end else begin
            illegal <= 1'b1;
            state   <= IDLE;
          end
        end
        ISSUE: begin
          cur_player <= ~cur_player;
          if (move_count != MAX_W) move_count <= move_count + 6'd1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
